// File: rtl/poly_mult_modq_ctrl.sv
// Schoolbook polynomial multiplier over Z_Q with optional reduction modulo
// x^P - x - 1. It drives external A, B and product memories with 1-cycle read latency.
module poly_mult_modq_ctrl #(
  parameter int P  = 757,
  parameter int Q  = 5167,
  parameter int CW = 13,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] dega,
  input  logic [AW-1:0] degb,
  input  logic          mode,
  output logic [AW-1:0] a_addr,
  input  logic [CW-1:0] a_rdata,
  output logic [AW-1:0] b_addr,
  input  logic [CW-1:0] b_rdata,
  output logic [AW-1:0] p_addr,
  output logic          p_we,
  output logic [CW-1:0] p_wdata,
  input  logic [CW-1:0] p_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] degc,
  output logic          zero,
  output logic [3:0]    o_dbg_state
);

  // Handshake: start is a one-cycle request and is accepted only in IDLE.
  // dega, degb and mode are captured in that same cycle. busy stays high until
  // the result is written. done then pulses for one cycle, and err, degc and
  // zero are valid with it. degc and zero hold until the next accepted start.

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLEAR  = 4'd1,
    S_MAC_RD = 4'd2,
    S_MAC_WR = 4'd3,
    S_F_RDH  = 4'd4,
    S_F_RDL  = 4'd5,
    S_F_WRL  = 4'd6,
    S_F_RDL1 = 4'd7,
    S_F_WRL1 = 4'd8,
    S_DEG    = 4'd9,
    S_DONE   = 4'd10
  } state_t;

  localparam logic [AW-1:0]   P_A  = AW'(P);
  localparam logic [AW-1:0]   P_M1 = AW'(P - 1);
  localparam logic [AW-1:0]   ONE  = AW'(1);
  localparam logic [2*CW:0]   QM   = (2*CW+1)'(Q);
  localparam logic [CW:0]     QF   = (CW+1)'(Q);

  state_t        r_state;
  logic [AW-1:0] r_dega;
  logic [AW-1:0] r_degb;
  logic          r_mode;
  logic [AW-1:0] r_sum;
  logic [AW-1:0] r_a_addr;
  logic [AW-1:0] r_b_addr;
  logic [AW-1:0] r_p_addr;
  logic [AW-1:0] r_k;
  logic [CW-1:0] r_hi;
  logic [AW-1:0] r_chk;
  logic          r_dvalid;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [AW-1:0] r_degc;
  logic          r_zero;

  logic [2*CW-1:0] w_prod;
  logic [2*CW:0]   w_mac_sum;
  logic [CW:0]     w_fold_sum;
  logic [CW:0]     w_fold_red;
  logic [CW-1:0]   w_wdata;

  assign w_prod     = {{CW{1'b0}}, a_rdata} * {{CW{1'b0}}, b_rdata};
  assign w_mac_sum  = {1'b0, w_prod} + {{(CW+1){1'b0}}, p_rdata};
  // Both fold operands are already below Q, so one conditional subtract is enough.
  assign w_fold_sum = {1'b0, p_rdata} + {1'b0, r_hi};
  assign w_fold_red = (w_fold_sum >= QF) ? (w_fold_sum - QF) : w_fold_sum;

  // Write data depends on the read data that arrives in the write cycle.
  always_comb begin
    w_wdata = '0;
    case (r_state)
      S_MAC_WR:           w_wdata = CW'(w_mac_sum % QM);
      S_F_WRL, S_F_WRL1:  w_wdata = CW'(w_fold_red);
      default:            w_wdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_dega   <= '0;
      r_degb   <= '0;
      r_mode   <= 1'b0;
      r_sum    <= '0;
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_p_addr <= '0;
      r_k      <= '0;
      r_hi     <= '0;
      r_chk    <= '0;
      r_dvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_degc   <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dega <= dega;
            r_degb <= degb;
            r_mode <= mode;
            r_sum  <= dega + degb;
            r_err  <= 1'b0;
            r_degc <= '0;
            r_zero <= 1'b0;
            if ((dega > P_M1) || (degb > P_M1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state  <= S_CLEAR;
              r_busy   <= 1'b1;
              r_p_addr <= '0;
            end
          end
        end
        S_CLEAR: begin
          if (r_p_addr == r_sum) begin
            r_state  <= S_MAC_RD;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_p_addr <= '0;
          end else begin
            r_p_addr <= r_p_addr + ONE;
          end
        end
        S_MAC_RD: begin
          r_state <= S_MAC_WR;
        end
        S_MAC_WR: begin
          if (r_b_addr != r_degb) begin
            r_state  <= S_MAC_RD;
            r_b_addr <= r_b_addr + ONE;
            r_p_addr <= r_p_addr + ONE;
          end else if (r_a_addr != r_dega) begin
            r_state  <= S_MAC_RD;
            r_a_addr <= r_a_addr + ONE;
            r_b_addr <= '0;
            r_p_addr <= r_a_addr + ONE;
          end else if (r_mode && (r_sum >= P_A)) begin
            r_state  <= S_F_RDH;
            r_k      <= P_A;
            r_p_addr <= P_A;
          end else begin
            r_state  <= S_DEG;
            r_p_addr <= r_sum;
            r_dvalid <= 1'b0;
          end
        end
        // Fold x^k = x^(k-P) * (x + 1): coefficient k lands on k-P and k-P+1.
        S_F_RDH: begin
          r_state  <= S_F_RDL;
          r_p_addr <= r_k - P_A;
        end
        S_F_RDL: begin
          r_state <= S_F_WRL;
          r_hi    <= p_rdata;
        end
        S_F_WRL: begin
          r_state  <= S_F_RDL1;
          r_p_addr <= r_p_addr + ONE;
        end
        S_F_RDL1: begin
          r_state <= S_F_WRL1;
        end
        S_F_WRL1: begin
          if (r_k == r_sum) begin
            r_state  <= S_DEG;
            r_p_addr <= P_M1;
            r_dvalid <= 1'b0;
          end else begin
            r_state  <= S_F_RDH;
            r_k      <= r_k + ONE;
            r_p_addr <= r_k + ONE;
          end
        end
        // r_chk trails the presented address by one cycle and matches p_rdata.
        S_DEG: begin
          r_dvalid <= 1'b1;
          r_chk    <= r_p_addr;
          if (r_p_addr != '0) r_p_addr <= r_p_addr - ONE;
          if (r_dvalid && (p_rdata != '0)) begin
            r_degc   <= r_chk;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_p_addr <= '0;
          end else if (r_dvalid && (r_chk == '0)) begin
            r_degc   <= '0;
            r_zero   <= 1'b1;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_p_addr <= '0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a_addr      = r_a_addr;
  assign b_addr      = r_b_addr;
  assign p_addr      = r_p_addr;
  assign p_we        = (r_state == S_CLEAR) || (r_state == S_MAC_WR) ||
                       (r_state == S_F_WRL) || (r_state == S_F_WRL1);
  assign p_wdata     = w_wdata;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign degc        = r_degc;
  assign zero        = r_zero;
  assign o_dbg_state = r_state;

endmodule
